// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared FSM state type and sizing constants for the multiply/divide unit
package mult_div_pkg;
   typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} md_state_t;
   localparam int MD_WIDTH = 32;
   localparam int MD_ITER = MD_WIDTH;
   localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;
endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one combinational iteration of shift-add multiply or restoring divide
// ports: i_div selects divide; i_hi/i_lo is the {acc,multiplier} or {rem,quot} pair;
//        i_operand is the multiplicand or divisor magnitude; o_hi/o_lo is the updated pair
module mult_div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_operand,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shl;
   logic [WIDTH:0] w_diff;
   logic           w_borrow;
   always_comb begin
      w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
      w_shl    = {i_hi, i_lo[WIDTH-1]};
      w_diff   = w_shl - {1'b0, i_operand};
      // remainder stays below the divisor, so a set top bit can only mean the trial went negative
      w_borrow = w_diff[WIDTH];
      o_hi     = i_div ? (w_borrow ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
      o_lo     = i_div ? {i_lo[WIDTH-2:0], ~w_borrow} : {w_sum[0], i_lo[WIDTH-1:1]};
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide producing HI/LO with one-cycle done pulses
// ports: clk/reset (sync, active-high); mult_start/div_start accepted in IDLE with op_a/op_b;
//        hi/lo result; mult_done/div_done pulse in DONE; div_by_zero with div_done; busy
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             mult_done,
   output logic             div_done,
   output logic             div_by_zero,
   output logic             busy
);
   localparam int ITER = (WIDTH == MD_WIDTH) ? MD_ITER : WIDTH;
   localparam int CW = $clog2(ITER + 1);
   localparam logic [WIDTH-1:0] LO0 = (WIDTH == MD_WIDTH) ? WIDTH'(DIV0_LO) : '1;

   md_state_t        r_state, w_next;
   logic             r_op_div, r_sa, r_sb, r_dz;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_operand, r_acc, r_q, r_hi, r_lo;
   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_step_hi, w_step_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic             w_neg, w_last, w_div0, w_accept;

   assign w_abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
   assign w_abs_b  = op_b[WIDTH-1] ? -op_b : op_b;
   assign w_neg    = r_sa ^ r_sb;
   assign w_prod   = w_neg ? -{r_acc, r_q} : {r_acc, r_q};
   assign w_last   = r_count == CW'(ITER - 1);
   assign w_accept = mult_start | div_start;
   assign w_div0   = !mult_start && div_start && op_b == '0;

   mult_div_step #(.WIDTH(WIDTH)) u_step (
      .i_div     (r_op_div),
      .i_hi      (r_acc),
      .i_lo      (r_q),
      .i_operand (r_operand),
      .o_hi      (w_step_hi),
      .o_lo      (w_step_lo)
   );

   always_ff @(posedge clk)
      r_state <= reset ? S_IDLE : w_next;

   always_comb begin
      w_next      = r_state;
      busy        = r_state != S_IDLE;
      mult_done   = r_state == S_DONE && !r_op_div;
      div_done    = r_state == S_DONE && r_op_div;
      div_by_zero = r_state == S_DONE && r_op_div && r_dz;
      case (r_state)
         S_IDLE:         w_next = mult_start ? S_MULT : !div_start ? S_IDLE : w_div0 ? S_DONE : S_DIV;
         S_MULT, S_DIV:  w_next = w_last ? S_FIX : r_state;
         S_FIX:          w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_div  <= 1'b0;
         r_sa      <= 1'b0;
         r_sb      <= 1'b0;
         r_dz      <= 1'b0;
         r_count   <= '0;
         r_operand <= '0;
         r_acc     <= '0;
         r_q       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op_div  <= !mult_start;
               r_sa      <= op_a[WIDTH-1];
               r_sb      <= op_b[WIDTH-1];
               r_dz      <= w_div0;
               r_count   <= '0;
               r_acc     <= '0;
               // multiply iterates over the multiplier bits, divide shifts the dividend out
               r_operand <= mult_start ? w_abs_a : w_abs_b;
               r_q       <= mult_start ? w_abs_b : w_abs_a;
               if (w_div0) begin
                  r_hi <= op_a;
                  r_lo <= LO0;
               end
            end
            S_MULT, S_DIV: begin
               r_acc   <= w_step_hi;
               r_q     <= w_step_lo;
               r_count <= r_count + 1'b1;
            end
            S_FIX: begin
               r_hi <= r_op_div ? (r_sa ? -r_acc : r_acc) : w_prod[2*WIDTH-1:WIDTH];
               r_lo <= r_op_div ? (w_neg ? -r_q : r_q) : w_prod[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against a signed-arithmetic model
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mult_start = 1'b0;
   logic        div_start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] hi, lo;
   logic        mult_done, div_done, div_by_zero, busy;
   int          total = 0;
   int          bad = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .mult_start  (mult_start),
      .div_start   (div_start),
      .op_a        (op_a),
      .op_b        (op_b),
      .hi          (hi),
      .lo          (lo),
      .mult_done   (mult_done),
      .div_done    (div_done),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input bit m, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      sa = $signed(a);
      sb = $signed(b);
      if (m) begin
         p = sa * sb;
         return p;
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pick(output logic [31:0] v, input bit allow_zero);
      case ($urandom_range(0, 6))
         0: v = allow_zero ? 32'h0 : 32'h1;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'($signed($urandom_range(0, 40)) - 20);
         default: v = $urandom;
      endcase
   endtask

   task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                      input int inj_at, input int rst_at);
      logic [63:0] exp;
      bit          dz, busy_ok;
      int          exp_cyc, busy_end, done_cyc, ndone, nwrong;
      logic [31:0] h, l;
      logic        z;
      dz       = !m && b == 0;
      exp      = model(m, a, b);
      exp_cyc  = dz ? 1 : 34;
      busy_end = rst_at > 0 ? rst_at : exp_cyc;
      done_cyc = -1;
      ndone    = 0;
      nwrong   = 0;
      busy_ok  = 1;
      h = '0;
      l = '0;
      z = 1'b0;
      @(negedge clk);
      mult_start = m;
      div_start  = d;
      op_a       = a;
      op_b       = b;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == rst_at + 1) begin
            chk("rst_busy", busy, 0);
            chk("rst_hi", hi, 0);
            chk("rst_lo", lo, 0);
         end
         if (m ? mult_done : div_done) begin
            ndone++;
            done_cyc = k;
            h = hi;
            l = lo;
            z = div_by_zero;
         end
         if (m ? div_done : mult_done) nwrong++;
         if (busy !== (k <= busy_end)) busy_ok = 0;
         mult_start = 1'b0;
         div_start  = (k == inj_at);
         reset      = (k == rst_at);
         op_a       = $urandom;
         op_b       = $urandom;
      end
      if (rst_at > 0) begin
         chk("rst_no_done", ndone, 0);
      end else begin
         chk("done_cycle", done_cyc, exp_cyc);
         chk("done_count", ndone, 1);
         chk("result", {h, l}, exp);
         chk("div_by_zero", z, dz);
         chk("hold", {hi, lo}, exp);
      end
      chk("other_done", nwrong, 0);
      chk("busy_window", busy_ok, 1);
   endtask

   initial begin
      logic [31:0] a, b;
      bit          m;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      chk("reset_mdone", mult_done, 0);
      chk("reset_ddone", div_done, 0);
      chk("reset_dz", div_by_zero, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      mult_start = 1'b1;
      op_a = 32'd3;
      op_b = 32'd3;
      @(posedge clk);
      #1;
      chk("reset_beats_start", busy, 0);
      mult_start = 1'b0;
      reset = 1'b0;
      run(1, 0, 32'd7, 32'hFFFF_FFFD, -1, -1);
      run(0, 1, 32'hFFFF_FFF9, 32'd2, -1, -1);
      run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      run(1, 0, 32'h8000_0000, 32'h8000_0000, -1, -1);
      run(0, 1, 32'd5, 32'd0, -1, -1);
      run(1, 1, 32'd6, 32'd4, 10, -1);
      run(1, 0, 32'h1234_5678, 32'h0FED_CBA9, -1, 15);
      run(1, 0, 32'd3, 32'd3, -1, -1);
      for (int i = 0; i < 24; i++) begin
         m = 1'($urandom_range(0, 1));
         pick(a, 1'b1);
         pick(b, $urandom_range(0, 3) == 0);
         run(m, !m, a, b, -1, -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
